hazard_stall_unit: RTL
======================

// Module: hazard_stall_unit
// PURPOSE
//  Pipeline hazard controller for the 5-stage core. Drives SS into the ID control mux (bubble insertion),
//  load enables for PC and IF/ID, IF/ID flush on taken branch, and operand forwarding selects.
//  Keeps its own shadow of EX/MEM/WB destination info, sampled from post-mux ID controls.
//  Includes a global freeze on memory wait and a saturating stall-cycle counter.
// PARAMETERS
//  REG_AW  4   register-address width (16 architectural regs)
//  PC_REG  15  register index never forwarded (reads PC path)
//  CNT_W   16  stall counter width
// PORTS
//  clk            in   1       rising-edge clock
//  reset_n        in   1       asynchronous reset, active-low
//  id_rn,id_rm,id_rd in REG_AW ID-stage source/dest register fields
//  id_use_rn,id_use_rm,id_use_rd in 1 ID instr reads Rn/Rm/Rd (Rd read = store data)
//  id_rf_enable   in   1       post-mux ID_RF_enable (0 for bubbles)
//  id_load_instr  in   1       post-mux ID_load_instr
//  id_branch_taken in  1       B/BL resolved taken in ID
//  mem_busy       in   1       data memory not ready this cycle
//  SS             out  1       1 = force ID controls to NOP
//  PC_LE, IF_ID_LE out 1       load enables
//  IF_ID_flush    out  1       IF/ID loads NOP at next edge
//  pipe_hold      out  1       freeze ID/EX, EX/MEM, MEM/WB registers
//  fwd_rn_sel,fwd_rm_sel,fwd_rd_sel out 2 00 RF, 01 EX, 10 MEM, 11 WB
//  hz_state       out  2       current FSM state
//  stall_cycles   out  CNT_W   saturating count of cycles with SS=1 or pipe_hold=1
// BEHAVIOUR
//  Reset: state RUN, shadow we/load bits 0, rd fields 0, stall_cycles 0.
//   Outputs then: SS=0, PC_LE=1, IF_ID_LE=1, IF_ID_flush=0, pipe_hold=0, fwd_*=00.
//  Shadow pipe: each edge with pipe_hold=0, ID->EX->MEM->WB shift {rd, we=id_rf_enable&~SS, load}.
//   Bubble (SS=1) enters EX with we=0. When pipe_hold=1, all shadow regs hold.
//  Forwarding (comb.): for src r with use=1 and r!=PC_REG, match EX we&rd==r (not load) -> 01,
//   else MEM we&rd==r -> 10, else WB we&rd==r -> 11, else 00. Youngest stage wins; use=0 -> 00.
//  Load-use (comb.): used src matches EX rd with EX we&load -> SS=1, PC_LE=0, IF_ID_LE=0 same cycle.
//   Exactly one bubble per load; next cycle the load is in MEM and forwards via 10.
//  Branch: id_branch_taken & ~SS & ~mem_busy -> IF_ID_flush=1 that cycle, PC_LE=1.
//  mem_busy (highest priority): pipe_hold=1, PC_LE=0, IF_ID_LE=0, SS=0, IF_ID_flush=0.
//  FSM (registered): RUN=0, STALL=1, WAIT=2.
//   Next state, any state: mem_busy -> WAIT, else load-use -> STALL, else RUN. Encoding 3 unused -> RUN.
//  Priority: mem_busy > load-use > branch flush.
//   A branch in ID during a load-use stall is ignored and re-evaluated next cycle.
//  Counter increments by 1 each cycle SS|pipe_hold; saturates at all-ones, no wrap.
//  Reset mid-stall: all state cleared async; first cycle after release behaves as RUN.
// STRUCTURE
//  Package hz_pkg: state enum {HZ_RUN, HZ_STALL, HZ_WAIT}, FWD_RF/EX/MEM/WB 2-bit constants.
//  One sub-module hz_fwd_sel (pure comb. priority select), instantiated 3x (Rn, Rm, Rd).
//  Top holds shadow regs, FSM, counter, stall/flush logic.
// TESTING
//  Load r1 then ADD r2,r1,r3 -> one cycle SS=1, PC_LE=0, hz_state=STALL; next cycle fwd_rn_sel=10.
//  ADD r1 then SUB using r1 (Rm) -> no stall, fwd_rm_sel=01; separated by 2 instrs -> 11.
//  Src r15 with EX rd=15 we=1 -> fwd sel 00, no stall.
//  mem_busy held 3 cycles during load-use -> pipe_hold=1 for 3, SS=0; STALL resolves after release.
//  Taken branch in ID, no hazard -> IF_ID_flush=1 one cycle; together with load-use -> flush=0, SS=1.
//  Force 2^16 stall cycles -> stall_cycles stays 16'hFFFF.
//  reset_n low mid-STALL -> all outputs at reset values immediately, async.

Source files
------------

// File: rtl/hz_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hz_pkg;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_STALL = 2'd1,
        HZ_WAIT  = 2'd2
    } hz_state_e;

    localparam int unsigned FWD_W = 2;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EX  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b11;

endpackage

// File: rtl/hz_fwd_sel.sv
// Operand forwarding select for one source register; youngest producing stage wins.
module hz_fwd_sel
    import hz_pkg::*;
#(
    parameter int unsigned REG_AW = 4,
    parameter int unsigned PC_REG = 15
) (
    input  logic [REG_AW-1:0] src,
    input  logic              src_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_we,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    output logic [FWD_W-1:0]  sel_c
);

    // A load in EX has no data yet; it is covered by the load-use bubble instead.
    always_comb begin
        sel_c = FWD_RF;
        if (src_used && (src != REG_AW'(PC_REG))) begin
            if (ex_we && !ex_load && (ex_rd == src)) begin
                sel_c = FWD_EX;
            end else if (mem_we && (mem_rd == src)) begin
                sel_c = FWD_MEM;
            end else if (wb_we && (wb_rd == src)) begin
                sel_c = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard controller: load-use bubbles, branch flush, memory-wait freeze,
// operand forwarding and a saturating stall-cycle counter.
module hazard_stall_unit
    import hz_pkg::*;
#(
    parameter int unsigned REG_AW = 4,
    parameter int unsigned PC_REG = 15,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rn,
    input  logic              id_use_rm,
    input  logic              id_use_rd,
    input  logic              id_rf_enable,
    input  logic              id_load_instr,
    input  logic              id_branch_taken,
    input  logic              mem_busy,
    output logic              SS,
    output logic              PC_LE,
    output logic              IF_ID_LE,
    output logic              IF_ID_flush,
    output logic              pipe_hold,
    output logic [FWD_W-1:0]  fwd_rn_sel,
    output logic [FWD_W-1:0]  fwd_rm_sel,
    output logic [FWD_W-1:0]  fwd_rd_sel,
    output logic [1:0]        hz_state,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hz_state_e         state;
    logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
    logic              ex_we, mem_we, wb_we;
    logic              ex_load, mem_load, wb_load;
    logic              src_hit_c;
    logic              load_use_c;

    // Any used ID source that names the destination of a load sitting in EX.
    always_comb begin
        src_hit_c = (id_use_rn && (id_rn == ex_rd))
                 || (id_use_rm && (id_rm == ex_rd))
                 || (id_use_rd && (id_rd == ex_rd));
        load_use_c = !mem_busy && ex_we && ex_load && src_hit_c;
    end

    assign SS          = load_use_c;
    assign pipe_hold   = mem_busy;
    assign PC_LE       = !mem_busy && !load_use_c;
    assign IF_ID_LE    = !mem_busy && !load_use_c;
    assign IF_ID_flush = id_branch_taken && !load_use_c && !mem_busy;
    assign hz_state    = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= HZ_RUN;
        end else if (mem_busy) begin
            state <= HZ_WAIT;
        end else if (load_use_c) begin
            state <= HZ_STALL;
        end else begin
            state <= HZ_RUN;
        end
    end

    // Shadow of destination info travelling down EX/MEM/WB; frozen with the pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_rd    <= '0;
            mem_rd   <= '0;
            wb_rd    <= '0;
            ex_we    <= 1'b0;
            mem_we   <= 1'b0;
            wb_we    <= 1'b0;
            ex_load  <= 1'b0;
            mem_load <= 1'b0;
            wb_load  <= 1'b0;
        end else if (!pipe_hold) begin
            ex_rd    <= id_rd;
            ex_we    <= id_rf_enable && !load_use_c;
            ex_load  <= id_load_instr;
            mem_rd   <= ex_rd;
            mem_we   <= ex_we;
            mem_load <= ex_load;
            wb_rd    <= mem_rd;
            wb_we    <= mem_we;
            wb_load  <= mem_load;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if ((load_use_c || mem_busy) && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    hz_fwd_sel #(.REG_AW(REG_AW), .PC_REG(PC_REG)) u_fwd_rn (
        .src(id_rn), .src_used(id_use_rn),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load),
        .mem_rd(mem_rd), .mem_we(mem_we), .wb_rd(wb_rd), .wb_we(wb_we),
        .sel_c(fwd_rn_sel)
    );

    hz_fwd_sel #(.REG_AW(REG_AW), .PC_REG(PC_REG)) u_fwd_rm (
        .src(id_rm), .src_used(id_use_rm),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load),
        .mem_rd(mem_rd), .mem_we(mem_we), .wb_rd(wb_rd), .wb_we(wb_we),
        .sel_c(fwd_rm_sel)
    );

    hz_fwd_sel #(.REG_AW(REG_AW), .PC_REG(PC_REG)) u_fwd_rd (
        .src(id_rd), .src_used(id_use_rd),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load),
        .mem_rd(mem_rd), .mem_we(mem_we), .wb_rd(wb_rd), .wb_we(wb_we),
        .sel_c(fwd_rd_sel)
    );

    logic unused_load;
    assign unused_load = mem_load ^ wb_load;

endmodule
